// File: rtl/seq_div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per clock,
// returns {remainder, quotient} with sign fix-up applied on the final write.
module seq_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   div_op1,
  input  logic [WIDTH-1:0]   div_op2,
  input  logic               annul,
  output logic               busy,
  output logic               is_done,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dsr_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic             q_neg_r;
  logic             r_neg_r;

  logic             a_neg_s;
  logic             b_neg_s;
  logic [WIDTH-1:0] a_mag_s;
  logic [WIDTH-1:0] b_mag_s;
  logic             div_zero_s;
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH-1:0] rem_next_s;
  logic             q_bit_s;
  logic [WIDTH-1:0] quo_next_s;
  logic [WIDTH-1:0] quo_fix_s;
  logic [WIDTH-1:0] rem_fix_s;

  // Operand conditioning: magnitudes in signed mode, pass-through otherwise.
  always_comb begin
    a_neg_s    = signed_div & div_op1[WIDTH-1];
    b_neg_s    = signed_div & div_op2[WIDTH-1];
    a_mag_s    = a_neg_s ? (~div_op1 + {{(WIDTH-1){1'b0}}, 1'b1}) : div_op1;
    b_mag_s    = b_neg_s ? (~div_op2 + {{(WIDTH-1){1'b0}}, 1'b1}) : div_op2;
    div_zero_s = (div_op2 == {WIDTH{1'b0}});
  end

  // One restoring step plus the sign-corrected values for the final write.
  always_comb begin
    shifted_s = {rem_r, dvd_r[WIDTH-1]};
    trial_s   = shifted_s - {1'b0, dsr_r};
    if (!trial_s[WIDTH]) begin
      rem_next_s = trial_s[WIDTH-1:0];
      q_bit_s    = 1'b1;
    end else begin
      rem_next_s = shifted_s[WIDTH-1:0];
      q_bit_s    = 1'b0;
    end
    quo_next_s = {quo_r[WIDTH-2:0], q_bit_s};
    quo_fix_s  = q_neg_r ? (~quo_next_s + {{(WIDTH-1){1'b0}}, 1'b1}) : quo_next_s;
    rem_fix_s  = r_neg_r ? (~rem_next_s + {{(WIDTH-1){1'b0}}, 1'b1}) : rem_next_s;
  end

  // Control FSM with registered busy / is_done / result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      dvd_r   <= {WIDTH{1'b0}};
      dsr_r   <= {WIDTH{1'b0}};
      rem_r   <= {WIDTH{1'b0}};
      quo_r   <= {WIDTH{1'b0}};
      q_neg_r <= 1'b0;
      r_neg_r <= 1'b0;
      busy    <= 1'b0;
      is_done <= 1'b0;
      result  <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start && !annul) begin
            if (div_zero_s) begin
              // Divide by zero skips iteration; raw dividend is returned.
              result  <= {div_op1, {WIDTH{1'b1}}};
              is_done <= 1'b1;
              state_r <= DONE;
            end else begin
              dvd_r   <= a_mag_s;
              dsr_r   <= b_mag_s;
              rem_r   <= {WIDTH{1'b0}};
              quo_r   <= {WIDTH{1'b0}};
              q_neg_r <= a_neg_s ^ b_neg_s;
              r_neg_r <= a_neg_s;
              cnt_r   <= {CW{1'b0}};
              busy    <= 1'b1;
              state_r <= CALC;
            end
          end
        end
        CALC: begin
          if (annul) begin
            busy    <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            state_r <= IDLE;
          end else begin
            rem_r <= rem_next_s;
            quo_r <= quo_next_s;
            dvd_r <= {dvd_r[WIDTH-2:0], 1'b0};
            if (cnt_r == LAST_ITER) begin
              result  <= {rem_fix_s, quo_fix_s};
              is_done <= 1'b1;
              busy    <= 1'b0;
              cnt_r   <= {CW{1'b0}};
              state_r <= DONE;
            end else begin
              cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
          end
        end
        DONE: begin
          if (!start) begin
            is_done <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          is_done <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_unit.sv
// Directed self-checking bench for seq_div_unit; expected values are
// hand-computed quotient/remainder pairs.
module tb_seq_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] div_op1;
  logic [31:0] div_op2;
  logic        annul;
  logic        busy;
  logic        is_done;
  logic [63:0] result;

  int pass_cnt = 0;
  int total_cnt = 0;

  seq_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .div_op1(div_op1), .div_op2(div_op2), .annul(annul),
    .busy(busy), .is_done(is_done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue a request and wait for is_done; lat counts edges after the accept edge.
  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res, output int lat, output int bc);
    signed_div = s; div_op1 = a; div_op2 = b; start = 1'b1;
    tick;
    lat = 0; bc = 0;
    while (!is_done && lat < 100) begin
      if (busy) bc++;
      tick;
      lat++;
    end
    res = result;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    div_op1 = 32'd0; div_op2 = 32'd0;
    tick; tick;
    rst = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (is_done !== 1'b0) $display("FAIL reset_done got %b want 0", is_done); else pass_cnt++;
    total_cnt++; if (result !== 64'd0) $display("FAIL reset_result got %h want 0", result); else pass_cnt++;
  endtask

  task automatic test_unsigned;
    logic [63:0] r; int lat; int bc;
    run_div(1'b0, 32'd100, 32'd7, r, lat, bc);
    total_cnt++; if (r !== 64'h0000_0002_0000_000E) $display("FAIL u100_7 got %h want 000000020000000e", r); else pass_cnt++;
    total_cnt++; if (lat !== 32) $display("FAIL u100_7_latency got %0d want 32", lat); else pass_cnt++;
    total_cnt++; if (bc !== 32) $display("FAIL u100_7_busy_cycles got %0d want 32", bc); else pass_cnt++;
    start = 1'b0; tick;
    total_cnt++; if (is_done !== 1'b0) $display("FAIL u100_7_release got %b want 0", is_done); else pass_cnt++;
  endtask

  task automatic test_signed;
    logic [63:0] r; int lat; int bc;
    run_div(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, r, lat, bc);
    total_cnt++; if (r !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL sm7_2 got %h want fffffffffffffffd", r); else pass_cnt++;
    start = 1'b0; tick;
    run_div(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, r, lat, bc);
    total_cnt++; if (r !== 64'h0000_0001_FFFF_FFFD) $display("FAIL s7_m2 got %h want 00000001fffffffd", r); else pass_cnt++;
    total_cnt++; if (lat !== 32) $display("FAIL s7_m2_latency got %0d want 32", lat); else pass_cnt++;
    start = 1'b0; tick;
  endtask

  task automatic test_boundary;
    logic [63:0] r; int lat; int bc;
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bc);
    total_cnt++; if (r !== 64'h0000_0000_8000_0000) $display("FAIL s_overflow got %h want 0000000080000000", r); else pass_cnt++;
    start = 1'b0; tick;
    run_div(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, r, lat, bc);
    total_cnt++; if (r !== 64'h0000_0000_FFFF_FFFF) $display("FAIL u_max_1 got %h want 00000000ffffffff", r); else pass_cnt++;
    start = 1'b0; tick;
    run_div(1'b0, 32'd5, 32'd9, r, lat, bc);
    total_cnt++; if (r !== 64'h0000_0005_0000_0000) $display("FAIL u5_9 got %h want 0000000500000000", r); else pass_cnt++;
    start = 1'b0; tick;
  endtask

  task automatic test_div_zero;
    logic [63:0] r; int lat; int bc;
    for (int m = 0; m < 2; m++) begin
      run_div(m[0], 32'h0000_04D2, 32'h0, r, lat, bc);
      total_cnt++; if (r !== 64'h0000_04D2_FFFF_FFFF) $display("FAIL dz%0d_result got %h want 000004d2ffffffff", m, r); else pass_cnt++;
      // lat 0: is_done already visible right after the accept edge
      total_cnt++; if (lat !== 0) $display("FAIL dz%0d_latency got %0d want 0", m, lat); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0 || bc !== 0) $display("FAIL dz%0d_busy got %b/%0d want 0/0", m, busy, bc); else pass_cnt++;
      start = 1'b0; tick;
    end
  endtask

  task automatic test_annul;
    logic [63:0] r; logic [63:0] prior; int lat; int bc; int done_seen;
    prior = result;
    signed_div = 1'b0; div_op1 = 32'd1000; div_op2 = 32'd3; start = 1'b1;
    tick;
    repeat (9) tick;
    annul = 1'b1; start = 1'b0;
    tick;
    annul = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL annul_busy got %b want 0", busy); else pass_cnt++;
    done_seen = 0;
    repeat (40) begin
      if (is_done) done_seen++;
      tick;
    end
    total_cnt++; if (done_seen !== 0) $display("FAIL annul_done got %0d want 0", done_seen); else pass_cnt++;
    total_cnt++; if (result !== prior) $display("FAIL annul_result got %h want %h", result, prior); else pass_cnt++;
    run_div(1'b0, 32'd9, 32'd3, r, lat, bc);
    total_cnt++; if (r !== 64'h0000_0000_0000_0003) $display("FAIL after_annul got %h want 0000000000000003", r); else pass_cnt++;
    start = 1'b0; tick;
  endtask

  task automatic test_hold;
    logic [63:0] r; int lat; int bc;
    run_div(1'b0, 32'd100, 32'd7, r, lat, bc);
    for (int i = 0; i < 5; i++) begin
      tick;
      total_cnt++; if (is_done !== 1'b1 || result !== 64'h0000_0002_0000_000E)
        $display("FAIL hold%0d got %b/%h want 1/000000020000000e", i, is_done, result); else pass_cnt++;
    end
    start = 1'b0; tick;
    total_cnt++; if (is_done !== 1'b0) $display("FAIL hold_release got %b want 0", is_done); else pass_cnt++;
    tick; tick; tick;
    total_cnt++; if (busy !== 1'b0 || is_done !== 1'b0) $display("FAIL hold_retrigger got %b/%b want 0/0", busy, is_done); else pass_cnt++;
  endtask

  task automatic test_start_drop_at_done;
    signed_div = 1'b0; div_op1 = 32'd20; div_op2 = 32'd4; start = 1'b1;
    tick;
    repeat (31) tick;
    start = 1'b0;
    tick;
    total_cnt++; if (is_done !== 1'b1 || result !== 64'h0000_0000_0000_0005)
      $display("FAIL drop_at_done got %b/%h want 1/0000000000000005", is_done, result); else pass_cnt++;
    tick;
    total_cnt++; if (is_done !== 1'b0) $display("FAIL drop_pulse got %b want 0", is_done); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    logic [63:0] r; int lat; int bc;
    signed_div = 1'b0; div_op1 = 32'd50; div_op2 = 32'd5; start = 1'b1;
    tick;
    repeat (20) tick;
    rst = 1'b1; start = 1'b0;
    tick;
    rst = 1'b0;
    total_cnt++; if (busy !== 1'b0 || is_done !== 1'b0 || result !== 64'd0)
      $display("FAIL rst_mid got %b/%b/%h want 0/0/0", busy, is_done, result); else pass_cnt++;
    run_div(1'b0, 32'd100, 32'd7, r, lat, bc);
    total_cnt++; if (r !== 64'h0000_0002_0000_000E || lat !== 32)
      $display("FAIL rst_fresh got %h/%0d want 000000020000000e/32", r, lat); else pass_cnt++;
    start = 1'b0; tick;
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_boundary;
    test_div_zero;
    test_annul;
    test_hold;
    test_start_drop_at_done;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
